// File: rtl/expr_eval_if.sv
// Character stream in, evaluated result out, for the expression evaluator.
// The source drives through master; the evaluator uses slave.
interface expr_eval_if #(
    parameter int W = 16
);
    logic [7:0]   in;
    logic         in_valid;
    logic [W-1:0] result;
    logic         result_valid;
    logic         err;
    logic         ovf;

    modport master (
        output in, in_valid,
        input  result, result_valid, err, ovf
    );

    modport slave (
        input  in, in_valid,
        output result, result_valid, err, ovf
    );
endinterface

// File: rtl/expr_eval.sv
// Evaluates "d{+|*}d...=" ASCII streams with '*' binding tighter than '+'.
// The result, error and wrap flags are registered and announced by a one-cycle result_valid pulse.
module expr_eval #(
    parameter int W = 16
) (
    input  logic      clk,
    input  logic      clr_n,
    expr_eval_if.slave bus
);
    typedef enum logic [1:0] {EXP_DIG, EXP_OP, ERR} state_t;

    state_t         state;
    logic [W-1:0]   sum;
    logic [W-1:0]   term;
    logic           mul_pend;
    logic           ovf_acc;

    logic           is_dig, is_add, is_mul, is_eq;
    logic [3:0]     dig;
    logic [2*W-1:0] mul_full;
    logic [W:0]     add_full;
    logic           finish;
    logic           fin_err;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        is_dig   = (bus.in >= 8'h30) && (bus.in <= 8'h39);
        is_add   = (bus.in == 8'h2b);
        is_mul   = (bus.in == 8'h2a);
        is_eq    = (bus.in == 8'h3d);
        dig      = 4'd0;
        if (is_dig)
            dig = 4'(bus.in - 8'h30);
        mul_full = {{W{1'b0}}, term} * {{(2*W-4){1'b0}}, dig};
        add_full = {1'b0, sum} + {1'b0, term};
        finish   = bus.in_valid && is_eq;
        // Only a completed operand (EXP_OP) ends a well-formed expression.
        fin_err  = (state != EXP_OP);
    end

    // NOTE: all state and registered outputs update with non-blocking assignments, so
    // every right-hand side below reads the value from before this clock edge.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state            <= EXP_DIG;
            sum              <= '0;
            term             <= '0;
            mul_pend         <= 1'b0;
            ovf_acc          <= 1'b0;
            bus.result       <= '0;
            bus.result_valid <= 1'b0;
            bus.err          <= 1'b0;
            bus.ovf          <= 1'b0;
        end else begin
            bus.result_valid <= 1'b0;
            if (finish) begin
                bus.result_valid <= 1'b1;
                bus.err          <= fin_err;
                bus.result       <= fin_err ? '0   : add_full[W-1:0];
                bus.ovf          <= fin_err ? 1'b0 : (ovf_acc | add_full[W]);
                state            <= EXP_DIG;
                sum              <= '0;
                term             <= '0;
                mul_pend         <= 1'b0;
                ovf_acc          <= 1'b0;
            end else if (bus.in_valid) begin
                unique case (state)
                    EXP_DIG: begin
                        if (is_dig) begin
                            if (mul_pend) begin
                                term    <= mul_full[W-1:0];
                                ovf_acc <= ovf_acc | (|mul_full[2*W-1:W]);
                            end else begin
                                term <= {{(W-4){1'b0}}, dig};
                            end
                            mul_pend <= 1'b0;
                            state    <= EXP_OP;
                        end else begin
                            state <= ERR;
                        end
                    end
                    EXP_OP: begin
                        if (is_add) begin
                            sum     <= add_full[W-1:0];
                            ovf_acc <= ovf_acc | add_full[W];
                            term    <= '0;
                            state   <= EXP_DIG;
                        end else if (is_mul) begin
                            mul_pend <= 1'b1;
                            state    <= EXP_DIG;
                        end else begin
                            state <= ERR;
                        end
                    end
                    ERR:     state <= ERR;
                    default: state <= ERR;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_expr_eval.sv
// Directed scoreboard bench for expr_eval: the driver queues expected results on '=',
// and a negedge monitor pops and compares them whenever result_valid is seen.
module tb_expr_eval;
    localparam int W = 16;

    typedef struct {
        logic [W-1:0] r;
        logic         e;
        logic         o;
        int           cyc;
    } exp_t;

    logic clk;
    logic clr_n;
    int   cyc;
    int   n_cmp;
    int   n_bad;
    exp_t sb[$];

    expr_eval_if #(.W(W)) bus ();

    expr_eval #(.W(W)) dut (
        .clk  (clk),
        .clr_n(clr_n),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every result_valid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (clr_n && bus.result_valid) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_pulse: got result=%0d err=%0d, expected no pulse (cycle %0d)",
                         bus.result, bus.err, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", 32'(bus.result), 32'(e.r));
                check("err", 32'(bus.err), 32'(e.e));
                check("ovf", 32'(bus.ovf), 32'(e.o));
                check("pulse_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic send_char(input byte ch);
        exp_t e;
        @(negedge clk);
        bus.in       = ch;
        bus.in_valid = 1'b1;
    endtask

    // Sends every character back to back; on '=' queues the expected outcome,
    // due in the cycle right after the one that accepts '='.
    task automatic send_str(input string s, input logic [W-1:0] r, input logic e, input logic o);
        for (int i = 0; i < s.len(); i++) begin
            send_char(s[i]);
            if (s[i] == "=") begin
                exp_t x;
                x.r   = r;
                x.e   = e;
                x.o   = o;
                x.cyc = cyc + 1;
                sb.push_back(x);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.in       = 8'($urandom);
            bus.in_valid = 1'b0;
        end
    endtask

    initial begin
        n_cmp        = 0;
        n_bad        = 0;
        cyc          = 0;
        bus.in       = 8'h00;
        bus.in_valid = 1'b0;
        clr_n        = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_result", 32'(bus.result), 0);
        check("reset_valid", 32'(bus.result_valid), 0);
        check("reset_err", 32'(bus.err), 0);
        check("reset_ovf", 32'(bus.ovf), 0);
        clr_n = 1'b1;
        idle(2);

        // Precedence, and back-to-back expressions with no dead cycle.
        send_str("1+2*3+4=", 16'd11, 1'b0, 1'b0);
        send_str("1+2+3=", 16'd6, 1'b0, 1'b0);
        send_str("2*3*4=", 16'd24, 1'b0, 1'b0);
        idle(2);

        // Multiply wrap at W=16, and a wrap only in the final add (59049*2 mod 2^16).
        send_str("9*9*9*9*9=", 16'd59049, 1'b0, 1'b0);
        send_str("9*9*9*9*9*9=", 16'd7153, 1'b0, 1'b1);
        send_str("9*9*9*9*9+9*9*9*9*9=", 16'd52562, 1'b0, 1'b1);
        idle(1);
        check("hold_ovf", 32'(bus.ovf), 1);
        check("hold_result", 32'(bus.result), 52562);

        // Malformed streams.
        send_str("1++2=", 16'd0, 1'b1, 1'b0);
        send_str("=", 16'd0, 1'b1, 1'b0);
        send_str("3+=", 16'd0, 1'b1, 1'b0);
        send_str("12=", 16'd0, 1'b1, 1'b0);
        send_str("+1=", 16'd0, 1'b1, 1'b0);
        send_str("4#5=", 16'd0, 1'b1, 1'b0);
        idle(2);
        check("hold_err", 32'(bus.err), 1);

        // Reset mid-expression clears outputs at once and drops the partial "1+2".
        send_str("1+2", 16'd0, 1'b0, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #2 clr_n = 1'b0;
        #1;
        check("async_clr_err", 32'(bus.err), 0);
        check("async_clr_result", 32'(bus.result), 0);
        #1 clr_n = 1'b1;
        send_str("5=", 16'd5, 1'b0, 1'b0);
        idle(3);

        // Idle gaps with garbage on the data lines must not disturb evaluation.
        send_char("7");
        idle($urandom_range(1, 4));
        send_char("*");
        idle($urandom_range(1, 4));
        send_char("8");
        idle($urandom_range(1, 4));
        check("hold_before_eq", 32'(bus.result), 5);
        send_str("=", 16'd56, 1'b0, 1'b0);
        idle(1);

        for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
        check("pulses_outstanding", sb.size(), 0);
        idle(5);
        check("no_late_pulse", 32'(bus.result_valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
